// File: rtl/ysyx_22040237_inst_fetch.sv
// Instruction fetch: single-outstanding request sequencer feeding a 2-entry instruction FIFO.
// Redirects flush the FIFO and mark any in-flight request so that its response is dropped.
module ysyx_22040237_inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc,
    output logic        inst_fault
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HALT = 2'd3} state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [63:0] fetch_pc_r;
    logic [63:0] req_addr_r;
    logic        drop_r;
    logic [63:0] fifo_pc_r    [2];
    logic [31:0] fifo_inst_r  [2];
    logic        fifo_fault_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;

    logic [63:0] redirect_addr_s;
    logic        handshake_s;
    logic        resp_take_s;
    logic        push_s;
    logic        pop_s;
    logic        issue_s;

    assign redirect_addr_s = redirect_pc & ~64'd3;
    assign handshake_s     = (state_r == REQ) && req_ready;
    assign resp_take_s     = (state_r == WAIT) && resp_valid;
    // A redirect discards a same-cycle response and overrides a same-cycle pop.
    assign push_s          = resp_take_s && !drop_r && !redirect_valid;
    assign pop_s           = (count_r != 2'd0) && inst_ready && !redirect_valid;
    assign issue_s         = (state_r == IDLE) && (state_next_s == REQ);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; IDLE only issues while FIFO has room for the reply.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (redirect_valid || (count_r < 2'd2)) state_next_s = REQ;
                else                                    state_next_s = IDLE;
            end
            REQ: begin
                if (req_ready) state_next_s = WAIT;
                else           state_next_s = REQ;
            end
            WAIT: begin
                if (!resp_valid)            state_next_s = WAIT;
                else if (push_s && resp_err) state_next_s = HALT;
                else                        state_next_s = IDLE;
            end
            HALT: begin
                if (redirect_valid) state_next_s = IDLE;
                else                state_next_s = HALT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: a request is presented only in REQ.
    always_comb begin
        req_valid = 1'b0;
        if (state_r == REQ) req_valid = 1'b1;
        else                req_valid = 1'b0;
    end

    // Fetch PC and the latched request address; the latter is frozen for the whole REQ phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
        end else begin
            if (redirect_valid)             fetch_pc_r <= redirect_addr_s;
            else if (handshake_s && !drop_r) fetch_pc_r <= fetch_pc_r + 64'd4;
            else                            fetch_pc_r <= fetch_pc_r;
            if (issue_s) req_addr_r <= redirect_valid ? redirect_addr_s : fetch_pc_r;
            else         req_addr_r <= req_addr_r;
        end
    end

    // Drop flag marks the single outstanding request as stale after a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else if (resp_take_s) begin
            drop_r <= 1'b0;
        end else if (redirect_valid && ((state_r == REQ) || (state_r == WAIT))) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Two-entry FIFO of {pc, inst, fault}; req_addr_r still holds the PC of the answered request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_pc_r[0]    <= 64'd0;
            fifo_pc_r[1]    <= 64'd0;
            fifo_inst_r[0]  <= 32'd0;
            fifo_inst_r[1]  <= 32'd0;
            fifo_fault_r[0] <= 1'b0;
            fifo_fault_r[1] <= 1'b0;
            rd_ptr_r        <= 1'b0;
            wr_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= req_addr_r;
                fifo_inst_r[wr_ptr_r]  <= resp_data;
                fifo_fault_r[wr_ptr_r] <= resp_err;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign req_addr   = req_addr_r;
    assign inst_valid = (count_r != 2'd0);
    assign inst_o     = fifo_inst_r[rd_ptr_r];
    assign inst_pc    = fifo_pc_r[rd_ptr_r];
    assign inst_fault = fifo_fault_r[rd_ptr_r];

endmodule

// File: tb/tb_ysyx_22040237_inst_fetch.sv
// Bench for ysyx_22040237_inst_fetch: a randomised memory responder and consumer, checked
// against an expected instruction-stream model (next PC, memory contents, fault rule).
module tb_ysyx_22040237_inst_fetch;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic        resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] inst_pc;
    logic        inst_fault;

    always #5 clk = ~clk;

    ysyx_22040237_inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o),
        .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    int checks = 0;
    int passes = 0;
    // memory responder state
    bit          outst = 1'b0;
    logic [63:0] pend = 64'd0;
    int          dly = 0, min_dly = 0, max_dly = 0, rdy_pct = 100, ird_pct = 100;
    logic [63:0] fault_addr = 64'h1;
    bit          rand_faults = 1'b0;
    logic [63:0] reqs[$];
    // expected instruction stream
    logic [63:0] exp_pc = RPC;
    bit          exp_halt = 1'b0;
    bit          saw_fault = 1'b0;
    int          consumed = 0;
    // previous-cycle hold obligations
    bit          prev_req_hold = 1'b0, prev_inst_hold = 1'b0;
    logic [63:0] prev_req_addr, prev_ipc;
    logic [31:0] prev_inst;
    logic        prev_ifault;

    function automatic logic [31:0] mem_word(input logic [63:0] pc);
        return {pc[31:2], 2'b11} ^ pc[63:32] ^ 32'h8000_0010;
    endfunction

    function automatic logic err_of(input logic [63:0] pc);
        return (pc == fault_addr) || (rand_faults && (pc[6:2] == 5'h1f));
    endfunction

    // One clock cycle: check hold rules, drive memory/consumer/redirect, advance model.
    task automatic tick(input bit redir, input logic [63:0] rpc);
        if (prev_req_hold) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== prev_req_addr)
                $display("FAIL req_stable: valid=%b addr=%h want valid=1 addr=%h", req_valid, req_addr, prev_req_addr);
            else passes++;
        end
        if (prev_inst_hold) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_o !== prev_inst || inst_pc !== prev_ipc || inst_fault !== prev_ifault)
                $display("FAIL inst_hold: pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst_o, prev_ipc, prev_inst);
            else passes++;
        end
        if (req_valid === 1'b1) begin
            checks++;
            if (outst) $display("FAIL one_outstanding: req_valid=1 with request pending, want 0");
            else passes++;
        end
        resp_valid = 1'b0; resp_data = 32'd0; resp_err = 1'b0;
        if (outst) begin
            if (dly == 0) begin
                resp_valid = 1'b1; resp_data = mem_word(pend); resp_err = err_of(pend); outst = 1'b0;
            end else dly--;
        end
        req_ready = (int'($urandom_range(99)) < rdy_pct);
        if (req_valid && req_ready) begin
            outst = 1'b1; pend = req_addr; reqs.push_back(req_addr);
            dly = min_dly + int'($urandom_range(max_dly - min_dly));
        end
        inst_ready = (int'($urandom_range(99)) < ird_pct);
        redirect_valid = redir; redirect_pc = rpc;
        if (inst_valid && inst_ready && !redir) begin
            checks++; consumed++;
            if (exp_halt)
                $display("FAIL fetch_after_fault: got pc=%h, want no instruction", inst_pc);
            else if (inst_pc !== exp_pc || inst_o !== mem_word(exp_pc) || inst_fault !== err_of(exp_pc))
                $display("FAIL inst_stream: pc=%h inst=%h flt=%b want pc=%h inst=%h flt=%b",
                         inst_pc, inst_o, inst_fault, exp_pc, mem_word(exp_pc), err_of(exp_pc));
            else passes++;
            if (err_of(exp_pc)) begin exp_halt = 1'b1; saw_fault = 1'b1; end
            exp_pc = exp_pc + 64'd4;
        end
        if (redir) begin exp_pc = rpc & ~64'd3; exp_halt = 1'b0; end
        prev_req_hold = req_valid && !req_ready; prev_req_addr = req_addr;
        prev_inst_hold = inst_valid && !inst_ready && !redir;
        prev_inst = inst_o; prev_ipc = inst_pc; prev_ifault = inst_fault;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        if (redir) begin
            checks++;
            if (inst_valid !== 1'b0) $display("FAIL flush: inst_valid=%b want 0", inst_valid);
            else passes++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 64'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1; outst = 1'b0; prev_req_hold = 1'b0; prev_inst_hold = 1'b0;
        redirect_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; inst_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        reqs.delete(); exp_pc = RPC; exp_halt = 1'b0; consumed = 0; saw_fault = 1'b0;
        rdy_pct = 100; ird_pct = 100; min_dly = 0; max_dly = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (req_valid !== 1'b0 || req_addr !== RPC || inst_valid !== 1'b0 || inst_o !== 32'd0 ||
            inst_pc !== 64'd0 || inst_fault !== 1'b0)
            $display("FAIL reset_outputs: rv=%b ra=%h iv=%b io=%h ip=%h if=%b want 0 %h 0 0 0 0",
                     req_valid, req_addr, inst_valid, inst_o, inst_pc, inst_fault, RPC);
        else passes++;
        min_dly = 3; max_dly = 3;
        for (int i = 0; i < 10 && !outst; i++) tick(1'b0, 64'd0);
        checks++;
        if (!outst) $display("FAIL reset_setup: no request accepted within bound");
        else passes++;
        rst = 1'b1; #1;
        checks++;
        if (req_valid !== 1'b0 || req_addr !== RPC || inst_valid !== 1'b0)
            $display("FAIL reset_mid: rv=%b ra=%h iv=%b want 0 %h 0", req_valid, req_addr, inst_valid, RPC);
        else passes++;
        apply_reset();
        run(10);
        checks++;
        if (reqs.size() < 1 || reqs[0] !== RPC || consumed < 1)
            $display("FAIL reset_restart: nreq=%0d consumed=%0d want first request %h", reqs.size(), consumed, RPC);
        else passes++;
    endtask

    task automatic test_basic();
        apply_reset();
        run(3);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0000 || inst_o !== 32'h0000_0013)
            $display("FAIL basic_first: iv=%b pc=%h inst=%h want 1 80000000 00000013", inst_valid, inst_pc, inst_o);
        else passes++;
        run(5);
        checks++;
        if (reqs.size() < 2 || reqs[0] !== 64'h8000_0000 || reqs[1] !== 64'h8000_0004 || consumed < 2)
            $display("FAIL basic_addrs: nreq=%0d consumed=%0d want 80000000,80000004", reqs.size(), consumed);
        else passes++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        ird_pct = 0; max_dly = 1;
        run(15);
        checks++;
        if (reqs.size() != 2 || req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== RPC)
            $display("FAIL bp_fill: nreq=%0d rv=%b iv=%b pc=%h want 2 0 1 %h", reqs.size(), req_valid, inst_valid, inst_pc, RPC);
        else passes++;
        ird_pct = 100; tick(1'b0, 64'd0);
        ird_pct = 0; run(10);
        checks++;
        if (reqs.size() != 3 || req_valid !== 1'b0 || inst_pc !== RPC + 64'd4)
            $display("FAIL bp_one_pop: nreq=%0d rv=%b pc=%h want 3 0 %h", reqs.size(), req_valid, inst_pc, RPC + 64'd4);
        else passes++;
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        min_dly = 3; max_dly = 3;
        run(2);
        tick(1'b1, 64'h8000_1002);
        min_dly = 0; max_dly = 0;
        run(15);
        checks++;
        if (reqs.size() < 2 || reqs[1] !== 64'h8000_1000 || consumed < 1)
            $display("FAIL redirect_wait: nreq=%0d consumed=%0d want second request 80001000", reqs.size(), consumed);
        else passes++;
    endtask

    task automatic test_redirect_coincident();
        bit found = 1'b0;
        apply_reset();
        ird_pct = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (outst && dly == 0 && inst_valid) found = 1'b1;
            else tick(1'b0, 64'd0);
        end
        checks++;
        if (!found) $display("FAIL coincident_setup: no response with full FIFO within bound");
        else passes++;
        ird_pct = 100;
        tick(1'b1, 64'h8000_2000);
        run(12);
        checks++;
        if (reqs.size() < 3 || reqs[2] !== 64'h8000_2000 || consumed < 1)
            $display("FAIL coincident_next: nreq=%0d consumed=%0d want third request 80002000", reqs.size(), consumed);
        else passes++;
    endtask

    task automatic test_fault();
        apply_reset();
        fault_addr = 64'h8000_0008;
        run(20);
        checks++;
        if (!saw_fault || reqs.size() != 3 || req_valid !== 1'b0)
            $display("FAIL fault_halt: fault=%b nreq=%0d rv=%b want 1 3 0", saw_fault, reqs.size(), req_valid);
        else passes++;
        tick(1'b1, 64'h8000_0100);
        run(10);
        checks++;
        if (reqs.size() < 4 || reqs[3] !== 64'h8000_0100 || consumed < 4)
            $display("FAIL fault_resume: nreq=%0d consumed=%0d want fourth request 80000100", reqs.size(), consumed);
        else passes++;
        fault_addr = 64'h1;
    endtask

    task automatic test_wrap();
        apply_reset();
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        run(10);
        checks++;
        if (reqs.size() < 2 || reqs[0] !== 64'hFFFF_FFFF_FFFF_FFFC || reqs[1] !== 64'd0)
            $display("FAIL wrap: nreq=%0d want FFFFFFFFFFFFFFFC then 0", reqs.size());
        else passes++;
    endtask

    task automatic test_random();
        logic [63:0] target;
        apply_reset();
        rand_faults = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            rdy_pct = int'($urandom_range(100, 20));
            ird_pct = int'($urandom_range(100, 10));
            max_dly = int'($urandom_range(3));
            for (int i = 0; i < 200; i++) begin
                target = {32'd0, 32'h8000_0000 | 32'($urandom_range(32'h0000_FFFF))};
                if (int'($urandom_range(99)) < (exp_halt ? 20 : 3)) tick(1'b1, target);
                else tick(1'b0, 64'd0);
            end
        end
        rand_faults = 1'b0;
        checks++;
        if (consumed < 100) $display("FAIL random_progress: consumed=%0d want at least 100", consumed);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_fault();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
